// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file slice.
package regfile_pkg;

    localparam int RF_WIDTH = 8;
    localparam int RF_DEPTH = 8;
    localparam int RF_AW    = 3;
    localparam int WRCNT_W  = 8;

    typedef logic [WRCNT_W-1:0] wrCount_t;

endpackage

// File: rtl/register_file_if.sv
// Write/read bus of the register file; master drives the request side,
// slave (the register file) returns the registered read data and write count.
interface register_file_if
    import regfile_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int AW    = RF_AW
);

    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [AW-1:0]    raddr_a;
    logic [AW-1:0]    raddr_b;
    logic [WIDTH-1:0] rdata_a;
    logic [WIDTH-1:0] rdata_b;
    wrCount_t         wr_count;

    modport master (
        output we, waddr, wdata, raddr_a, raddr_b,
        input  rdata_a, rdata_b, wr_count
    );

    modport slave (
        input  we, waddr, wdata, raddr_a, raddr_b,
        output rdata_a, rdata_b, wr_count
    );

endinterface

// File: rtl/register_n.sv
// One WIDTH-bit storage register with synchronous reset and load enable.
module register_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // Reset wins over a load; otherwise load when enabled, else hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/register_file.sv
// Register file with one write port and two registered read ports.
// Register 0 is hard-wired to zero; reads bypass a same-edge write.
module register_file
    import regfile_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int DEPTH = RF_DEPTH,
    parameter int AW    = RF_AW
) (
    input  logic              clk,
    input  logic              reset,
    register_file_if.slave    bus
);

    logic             writeAccept;
    logic [WIDTH-1:0] regQ [DEPTH];
    logic [WIDTH-1:0] rdataA_d;
    logic [WIDTH-1:0] rdataB_d;
    logic [WIDTH-1:0] rdataA_q;
    logic [WIDTH-1:0] rdataB_q;
    wrCount_t         wrCount_d;
    wrCount_t         wrCount_q;

    assign writeAccept = bus.we && (bus.waddr != '0);

    // Register 0 has no storage; it always reads as zero.
    assign regQ[0] = '0;

    for (genvar i = 1; i < DEPTH; i++) begin : gRegs
        register_n #(
            .WIDTH (WIDTH)
        ) uReg (
            .clk   (clk),
            .reset (reset),
            .en_i  (writeAccept && (bus.waddr == AW'(i))),
            .d_i   (bus.wdata),
            .q_o   (regQ[i])
        );
    end

    // Read muxes with write bypass, plus next value of the accepted-write counter.
    always_comb begin
        rdataA_d  = regQ[bus.raddr_a];
        rdataB_d  = regQ[bus.raddr_b];
        wrCount_d = wrCount_q;
        if (writeAccept && (bus.raddr_a == bus.waddr)) begin
            rdataA_d = bus.wdata;
        end
        if (writeAccept && (bus.raddr_b == bus.waddr)) begin
            rdataB_d = bus.wdata;
        end
        if (writeAccept) begin
            wrCount_d = wrCount_q + 1'b1;
        end
    end

    // Register read data and write count; reset clears both and drops any write.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdataA_q  <= '0;
            rdataB_q  <= '0;
            wrCount_q <= '0;
        end else begin
            rdataA_q  <= rdataA_d;
            rdataB_q  <= rdataB_d;
            wrCount_q <= wrCount_d;
        end
    end

    assign bus.rdata_a  = rdataA_q;
    assign bus.rdata_b  = rdataB_q;
    assign bus.wr_count = wrCount_q;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;
    import regfile_pkg::*;

    logic clk;
    logic reset;
    int   errorCount;
    int   checkCount;

    register_file_if #(.WIDTH(RF_WIDTH), .AW(RF_AW)) bus ();

    register_file #(
        .WIDTH (RF_WIDTH),
        .DEPTH (RF_DEPTH),
        .AW    (RF_AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle's worth of bus inputs.
    task automatic applyStimulus(input logic we, input logic [2:0] waddr,
                                 input logic [7:0] wdata,
                                 input logic [2:0] ra, input logic [2:0] rb);
        bus.we      = we;
        bus.waddr   = waddr;
        bus.wdata   = wdata;
        bus.raddr_a = ra;
        bus.raddr_b = rb;
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        errorCount = 0;
        checkCount = 0;
        reset      = 1'b1;
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
        tick();
        tick();
        reset = 1'b0;
        checkOutput("reset_count", 32'(bus.wr_count), 32'd0);
        checkOutput("reset_rdata_a", 32'(bus.rdata_a), 32'd0);

        // Every address reads zero after reset on both ports.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 3'd0, 8'h00, 3'(i), 3'(7 - i));
            tick();
            checkOutput($sformatf("post_reset_a%0d", i), 32'(bus.rdata_a), 32'd0);
            checkOutput($sformatf("post_reset_b%0d", 7 - i), 32'(bus.rdata_b), 32'd0);
        end
        checkOutput("post_reset_count", 32'(bus.wr_count), 32'd0);

        // Write 0xA5 to reg 3, read it back the next cycle.
        applyStimulus(1'b1, 3'd3, 8'hA5, 3'd0, 3'd0);
        tick();
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd3, 3'd0);
        tick();
        checkOutput("read_reg3", 32'(bus.rdata_a), 32'hA5);
        checkOutput("count_after_1", 32'(bus.wr_count), 32'd1);

        // Same-edge bypass on both ports to reg 5.
        applyStimulus(1'b1, 3'd5, 8'h3C, 3'd5, 3'd5);
        tick();
        checkOutput("bypass_a", 32'(bus.rdata_a), 32'h3C);
        checkOutput("bypass_b", 32'(bus.rdata_b), 32'h3C);
        checkOutput("count_after_2", 32'(bus.wr_count), 32'd2);
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd5, 3'd5);
        tick();
        checkOutput("stored_reg5_a", 32'(bus.rdata_a), 32'h3C);

        // Bypass on port B only, port A reads another register.
        applyStimulus(1'b1, 3'd6, 8'h77, 3'd3, 3'd6);
        tick();
        checkOutput("indep_a", 32'(bus.rdata_a), 32'hA5);
        checkOutput("indep_b", 32'(bus.rdata_b), 32'h77);
        checkOutput("count_after_3", 32'(bus.wr_count), 32'd3);

        // Writes to reg 0 are ignored and not counted.
        applyStimulus(1'b1, 3'd0, 8'hFF, 3'd0, 3'd0);
        tick();
        checkOutput("reg0_bypass", 32'(bus.rdata_a), 32'd0);
        checkOutput("reg0_count", 32'(bus.wr_count), 32'd3);
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
        tick();
        checkOutput("reg0_read", 32'(bus.rdata_b), 32'd0);

        // Contents stay put with we low; reads follow raddr every cycle.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 3'd6, 8'h99, 3'd6, 3'd3);
            tick();
        end
        checkOutput("stable_reg6", 32'(bus.rdata_a), 32'h77);
        checkOutput("stable_reg3", 32'(bus.rdata_b), 32'hA5);
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd5, 3'd1);
        tick();
        checkOutput("track_reg5", 32'(bus.rdata_a), 32'h3C);
        checkOutput("track_reg1", 32'(bus.rdata_b), 32'h00);

        // Reset beats a simultaneous write.
        reset = 1'b1;
        applyStimulus(1'b1, 3'd2, 8'h11, 3'd2, 3'd3);
        tick();
        reset = 1'b0;
        checkOutput("rst_write_count", 32'(bus.wr_count), 32'd0);
        checkOutput("rst_write_rdata", 32'(bus.rdata_a), 32'd0);
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd2, 3'd3);
        tick();
        checkOutput("rst_reg2", 32'(bus.rdata_a), 32'd0);
        checkOutput("rst_reg3", 32'(bus.rdata_b), 32'd0);

        // 255 writes cycling over regs 1..7, data = index.
        for (int i = 0; i < 255; i++) begin
            applyStimulus(1'b1, 3'((i % 7) + 1), 8'(i), 3'd0, 3'd0);
            tick();
        end
        checkOutput("count_255", 32'(bus.wr_count), 32'd255);
        // 256th write (i = 255 -> reg 4, data 0xFF) wraps the counter.
        applyStimulus(1'b1, 3'd4, 8'hFF, 3'd0, 3'd0);
        tick();
        checkOutput("count_wrap", 32'(bus.wr_count), 32'd0);
        // 257th write.
        applyStimulus(1'b1, 3'd1, 8'h42, 3'd0, 3'd0);
        tick();
        checkOutput("count_257", 32'(bus.wr_count), 32'd1);
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd4, 3'd1);
        tick();
        checkOutput("wrap_reg4", 32'(bus.rdata_a), 32'hFF);
        checkOutput("wrap_reg1", 32'(bus.rdata_b), 32'h42);
        // Reg 7 last written at i = 251 (0xFB), reg 2 at i = 253 (0xFD).
        applyStimulus(1'b0, 3'd0, 8'h00, 3'd7, 3'd2);
        tick();
        checkOutput("wrap_reg7", 32'(bus.rdata_a), 32'hFB);
        checkOutput("wrap_reg2", 32'(bus.rdata_b), 32'hFD);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bits per register.
REQ-002 SHALL have parameter DEPTH, default 8: number of registers, power of two.
REQ-003 SHALL have parameter AW, default 3: address width, equal to log2(DEPTH).
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port we, input, 1: write enable.
REQ-007 SHALL have port waddr, input, AW: write address.
REQ-008 SHALL have port wdata, input, WIDTH: write data.
REQ-009 SHALL have port raddr_a, input, AW: read port A address.
REQ-010 SHALL have port raddr_b, input, AW: read port B address.
REQ-011 SHALL have port rdata_a, output, WIDTH: registered read port A data.
REQ-012 SHALL have port rdata_b, output, WIDTH: registered read port B data.
REQ-013 SHALL have port wr_count, output, 8: count of accepted writes, wrapping.

Function
REQ-014 SHALL hold DEPTH registers of WIDTH bits; register 0 SHALL read as 0 at all times.
REQ-015 On a rising edge with we=1, reset=0 and waddr!=0, register[waddr] SHALL load wdata; all other registers SHALL hold.
REQ-016 A write to waddr=0 SHALL be ignored and SHALL NOT increment wr_count.
REQ-017 Reads SHALL have 1-cycle latency: rdata_x at edge N+1 reflects raddr_x sampled at edge N.
REQ-018 Same-cycle bypass: if we=1, waddr!=0 and raddr_x==waddr at an edge, rdata_x SHALL take wdata at that edge, not the old contents.
REQ-019 Ports A and B SHALL be independent; both SHALL be allowed to address the same register, including the bypass case.
REQ-020 wr_count SHALL increment by 1 on each accepted write (REQ-015) and SHALL wrap from 255 to 0.
REQ-021 With we=0, register contents SHALL be stable indefinitely; rdata SHALL track raddr each cycle.

Reset
REQ-022 While reset=1 at an edge, all registers, rdata_a, rdata_b and wr_count SHALL become 0.
REQ-023 Reset SHALL take priority over a simultaneous write; the write SHALL be lost and SHALL NOT be counted.
REQ-024 In the first cycle after reset deasserts, writes and reads SHALL behave normally; reads SHALL return 0 for every unwritten register.

Structure
REQ-025 WIDTH, DEPTH and AW defaults and the wr_count width SHALL be constants in a shared package (regfile_pkg).
REQ-026 Each storage register SHALL be an instance of one sub-module, register_n: a WIDTH-bit register with synchronous reset and load enable.
REQ-027 Write-address decode, read muxes, bypass compare and counter SHALL live in register_file itself.

Verification
REQ-028 Reset, then read all 8 addresses on both ports -> rdata_a = rdata_b = 0 and wr_count = 0.
REQ-029 Write 0xA5 to reg 3, then next cycle raddr_a=3 -> rdata_a=0xA5 one cycle later; wr_count=1.
REQ-030 we=1, waddr=5, wdata=0x3C, raddr_a=raddr_b=5 in the same cycle -> both rdata=0x3C at that edge.
REQ-031 Write 0xFF to reg 0, then read reg 0 -> rdata=0x00; wr_count unchanged.
REQ-032 reset=1 and we=1, waddr=2, wdata=0x11 in the same cycle -> reg 2 reads 0x00 and wr_count=0.
REQ-033 Perform 256 accepted writes -> wr_count wraps to 0; the 257th write -> wr_count=1.
